cordic_sched: RTL
=================

# cordic_sched

Scheduler sharing one iterative `cordic_top` core among `N_REQ` requesters (for example `qosc` instances and a control loop).
- Arbitrates requests round-robin and latches the winner's operands.
- Pulses the core's `start` and waits for `done` under a watchdog.
- Returns the core results to the granted requester through a valid/ready response channel.
- Sits between the requesters and the single `cordic_top` instance.

## Interface
- `N_REQ`, 4: number of requesters (2..8).
- `W`, 18: operand/result width, matching `cordic_top` x/y/z.
- `TIMEOUT`, 64: maximum cycles from `core_start` to `core_done` before an error response.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in N_REQ: per-requester request valid.
- `req_ready` out N_REQ: one-hot acceptance; asserted only in IDLE, for the granted requester.
- `req_x`, `req_y`, `req_z` in N_REQ*W each: packed operands; requester i occupies bits [i*W +: W].
- `rsp_valid` out N_REQ: one-hot response valid.
- `rsp_ready` in N_REQ: per-requester response accept.
- `rsp_x`, `rsp_y`, `rsp_z` out W each: shared response data, meaningful only where `rsp_valid` is set.
- `rsp_err` out 1: the response is a watchdog timeout; data is zero.
- `core_start` out 1: one-cycle start pulse to `cordic_top`.
- `core_x0`, `core_y0`, `core_z0` out W each: registered operands, stable from START until the next grant.
- `core_done` in 1: core completion.
- `core_xn`, `core_yn`, `core_zn` in W each: core results, sampled on the `core_done` cycle.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, START, BUSY, RESP.
- **IDLE**
  - When any `req_valid` is high, pick the requester g: first index at or after `ptr` (cyclic) with `req_valid` high.
  - Assert `req_ready[g]` combinationally.
  - Latch `req_x/y/z[g]` into `core_x0/y0/z0` and store g.
  - Go to START.
- **START**
  - Assert `core_start` for exactly one cycle.
  - Clear the watchdog counter.
  - Go to BUSY.
- **BUSY**
  - The counter increments each cycle.
  - On `core_done`: register `core_xn/yn/zn` into `rsp_x/y/z`, set `rsp_err`=0, go to RESP.
  - Otherwise, when the counter reaches `TIMEOUT`-1: set `rsp_x/y/z`=0, set `rsp_err`=1, go to RESP.
  - If `core_done` and timeout coincide, `core_done` wins.
- **RESP**
  - Hold `rsp_valid[g]`=1 and the data stable until `rsp_ready[g]`.
  - On the handshake: `ptr` ← (g+1) mod N_REQ, `rsp_valid` ← 0, go to IDLE.
- `core_done` outside BUSY is ignored and does not change state or data.
- `req_valid` may drop without a handshake; `req_ready` is only a grant in IDLE, and no requester is granted twice without its response completing.
- Requesters other than g see `req_ready`=0 throughout.
- Reset, asynchronous and at any point including mid-BUSY:
  - State is IDLE; `ptr`=0; the watchdog counter is cleared.
  - Every output is 0: `req_ready`, `rsp_valid`, `rsp_x/y/z`, `rsp_err`, `core_start`, `core_x0/y0/z0`, `busy`.
  - An in-flight core result is discarded. After reset release, the first `core_done` is ignored unless a new START has been issued.

## Timing
- Request accepted at edge k (IDLE, grant). START occupies cycle k+1 and `core_start` is high that cycle. BUSY begins at k+2.
- `core_done` at edge d gives `rsp_valid` high from cycle d+1.
- The next grant is possible in the cycle after the response handshake. Minimum turnaround per transaction = core latency + 4 cycles.
- A timeout produces the response `TIMEOUT`+1 cycles after the `core_start` cycle.
- `req_ready`, `busy` and `rsp_valid` are decoded from the registered state, with no path from `core_done` to any output in the same cycle. The one exception is `req_ready`, which depends combinationally on `req_valid` in IDLE.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,N_REQ-1,0.

## Structure
- Shared package `cordic_pkg`:
  - `CORDIC_W` = 18.
  - State encoding constants: IDLE=2'd0, START=2'd1, BUSY=2'd2, RESP=2'd3.
  - Default `TIMEOUT`.
- Sub-module `rr_arbiter`:
  - Inputs: `req[N_REQ]`, `ptr`.
  - Outputs: one-hot `gnt` and a binary index.
  - Purely combinational, instantiated once.
- Watchdog width: $clog2(TIMEOUT+1).

## Test plan
- Single request: req0 with x=1000, y=2000, z=43690. Core model asserts `done` 18 cycles after start and returns (1111, 2222, 3). Required: `core_start` exactly one pulse one cycle after grant; `rsp_valid[0]` with `rsp_x/y/z` = 1111/2222/3 and `rsp_err`=0.
- All four requesters held valid for 8 transactions. Required: grant order 0,1,2,3,0,1,2,3, and each response returns that requester's own operands echoed by the core model.
- Backpressure: `rsp_ready[1]` held low for 10 cycles. Required: `rsp_valid[1]` and the data stay stable, `busy`=1, and requester 2 gets no grant until the handshake.
- Watchdog, `TIMEOUT`=64: core model never asserts `done`. Required: `rsp_err`=1 with zero data 65 cycles after the `core_start` cycle. Then a late `done` with the FSM back in IDLE is ignored.
- Reset asserted mid-BUSY for a requester-2 transaction. Required: every output is 0 immediately. After release, a stray `done` produces no response, and the next request from requester 3 is granted first with `ptr`=0 ordering (0 wins if it is also valid).
- Simultaneous `core_done` and the timeout cycle. Required: normal response with `rsp_err`=0.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC scheduler slice: data width, FSM encoding
// and the default watchdog limit.
package cordic_pkg;

    localparam int CORDIC_W        = 18;
    localparam int DEFAULT_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/cordic_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr, wrapping
// around, and reports the winner both one-hot and as a binary index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PTR_W-1:0] idx,
    output logic             hit
);

    logic [PTR_W:0] cand;

    // Walk the requesters starting at ptr and keep the first valid one.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        hit  = 1'b0;
        cand = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (PTR_W + 1)'(k);
            if (cand >= (PTR_W + 1)'(N_REQ)) begin
                cand = cand - (PTR_W + 1)'(N_REQ);
            end
            if (!hit && req[cand[PTR_W-1:0]]) begin
                hit                   = 1'b1;
                idx                   = cand[PTR_W-1:0];
                gnt[cand[PTR_W-1:0]]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_sched.sv
// Scheduler that shares one iterative CORDIC core among N_REQ requesters:
// round-robin grant, one-cycle start pulse, watchdog on the core, and a
// valid/ready response back to the granted requester.
module cordic_sched
    import cordic_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int W       = CORDIC_W,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_x,
    input  logic [N_REQ*W-1:0] req_y,
    input  logic [N_REQ*W-1:0] req_z,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [W-1:0]       rsp_x,
    output logic [W-1:0]       rsp_y,
    output logic [W-1:0]       rsp_z,
    output logic               rsp_err,
    output logic               core_start,
    output logic [W-1:0]       core_x0,
    output logic [W-1:0]       core_y0,
    output logic [W-1:0]       core_z0,
    input  logic               core_done,
    input  logic [W-1:0]       core_xn,
    input  logic [W-1:0]       core_yn,
    input  logic [W-1:0]       core_zn,
    output logic               busy
);

    localparam int                 PTR_W    = $clog2(N_REQ);
    localparam int                 CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0]   IDX_LAST = PTR_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0]   ONE      = N_REQ'(1);

    sched_state_t       state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [CNT_W-1:0]   wd_cnt;

    logic [N_REQ-1:0]   arb_gnt;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_hit;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .hit (arb_hit)
    );

    // The grant is only offered while idle; reset also masks it so every
    // output is low the moment reset is asserted.
    assign req_ready = (rst && state == IDLE) ? arb_gnt : '0;
    assign busy      = (state != IDLE);

    // Main scheduler FSM: grant, start pulse, watchdog wait, response hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            gnt_idx    <= '0;
            wd_cnt     <= '0;
            core_start <= 1'b0;
            core_x0    <= '0;
            core_y0    <= '0;
            core_z0    <= '0;
            rsp_valid  <= '0;
            rsp_x      <= '0;
            rsp_y      <= '0;
            rsp_z      <= '0;
            rsp_err    <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_hit) begin
                        gnt_idx    <= arb_idx;
                        core_x0    <= req_x[int'(arb_idx)*W +: W];
                        core_y0    <= req_y[int'(arb_idx)*W +: W];
                        core_z0    <= req_z[int'(arb_idx)*W +: W];
                        core_start <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    wd_cnt <= '0;
                    state  <= BUSY;
                end
                BUSY: begin
                    if (core_done) begin
                        rsp_x     <= core_xn;
                        rsp_y     <= core_yn;
                        rsp_z     <= core_zn;
                        rsp_err   <= 1'b0;
                        rsp_valid <= ONE << gnt_idx;
                        state     <= RESP;
                    end else if (wd_cnt == CNT_LAST) begin
                        rsp_x     <= '0;
                        rsp_y     <= '0;
                        rsp_z     <= '0;
                        rsp_err   <= 1'b1;
                        rsp_valid <= ONE << gnt_idx;
                        state     <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready[gnt_idx]) begin
                        rsp_valid <= '0;
                        ptr       <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
